wshb_arbiter: RTL and testbench
===============================

// Module: wshb_arbiter
// PURPOSE
//   Two-master / one-slave Wishbone arbiter giving shared access to the SDRAM slave port.
//   Master 0 is the video read path (display FIFO filler); master 1 is the test-pattern writer.
//   Grants are cycle-based: the owner keeps the slave until it drops cyc.
//   Contention between cycles is resolved round-robin, with master 0 first after reset.
// PARAMETERS
//   AW  32  address width (byte addresses)
//   DW  32  data width; select width is DW/8
// PORTS
//   clk        in   1      system clock; all logic on its rising edge
//   rst        in   1      asynchronous reset, active high
//   m0_cyc     in   1      master 0 bus cycle request
//   m0_stb     in   1      master 0 strobe
//   m0_we      in   1      master 0 write enable
//   m0_adr     in   AW     master 0 address
//   m0_dat_ms  in   DW     master 0 write data
//   m0_sel     in   DW/8   master 0 byte select
//   m0_cti     in   3      master 0 cycle type
//   m0_bte     in   2      master 0 burst type
//   m0_ack     out  1      master 0 acknowledge
//   m0_dat_sm  out  DW     master 0 read data
//   m1_*       same set as m0_*, for master 1
//   s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte   out  widths as above  to slave
//   s_ack      in   1      slave acknowledge
//   s_dat_sm   in   DW     slave read data
//   gnt        out  2      one-hot current owner (bit0 = m0, bit1 = m1); 2'b00 when idle
// BEHAVIOUR
//   FSM states: IDLE, OWN0, OWN1. State and last_owner register reset asynchronously.
//   Reset values:
//     - state = IDLE, last_owner = 1, so m0 wins the first contention.
//     - All s_* outputs = 0, m*_ack = 0, gnt = 00.
//   IDLE transitions:
//     - m0_cyc only -> OWN0.
//     - m1_cyc only -> OWN1.
//     - Both -> OWN(the master != last_owner).
//     - Neither -> stay in IDLE.
//   OWNx transitions:
//     - Stay while mx_cyc = 1.
//     - When mx_cyc = 0, set last_owner = x and move on the same edge to:
//       OWNy if the other master's cyc = 1, else IDLE.
//     - Result: a switch costs no idle cycle, and an idle-to-grant decision costs 1 cycle.
//   Datapath mux (combinational from the registered state):
//     - OWNx: s_* = mx_* (s_cyc = mx_cyc, s_stb = mx_stb, ...); mx_ack = s_ack; my_ack = 0.
//     - IDLE: s_cyc = s_stb = 0, other s_* = 0, both acks = 0.
//     - m0_dat_sm = m1_dat_sm = s_dat_sm (broadcast; qualified by ack).
//   Grant-loss guard: s_ack is routed only to the owner; any s_ack in IDLE is dropped.
//   Owner holding time: the arbiter never preempts a cycle; fairness relies on masters dropping cyc.
//   gnt is decoded from the registered state: OWN0 -> 01, OWN1 -> 10, IDLE -> 00.
//   Asserting rst mid-cycle:
//     - Forces IDLE immediately; s_cyc/s_stb go low asynchronously.
//     - The in-flight transfer is abandoned and no ack reaches any master.
//   cyc dropping while stb is high with no ack: handled as an ordinary cycle end.
// TESTING
//   1. Reset, then m0_cyc = m0_stb = 1, adr = 0x100, slave acks every cycle:
//      -> gnt = 01 one cycle later, s_adr = 0x100, m0_ack mirrors s_ack, m1_ack = 0.
//   2. m0 and m1 both raise cyc in the same cycle after reset
//      -> OWN0 first; when m0 drops cyc, gnt goes to 10 on the same edge with no idle cycle.
//   3. Both masters request continuously, each dropping cyc after 4 acks
//      -> grants alternate 01, 10, 01, 10; each master gets exactly 4 acks per grant.
//   4. m1 owns the bus (we = 1, dat_ms = 0x00FFFF00); m0 raises cyc
//      -> m0 sees no ack until m1 drops cyc; no m0 field appears on s_* meanwhile.
//   5. rst pulsed for 1 cycle while OWN1 with stb = 1
//      -> s_cyc = 0 and gnt = 00 without waiting for a clock edge; m0 is granted first afterwards.
//   6. Slave asserts s_ack while IDLE
//      -> m0_ack = m1_ack = 0, and the state stays IDLE.

Source files
------------

// File: rtl/wshb_arbiter.sv
// Two-master / one-slave Wishbone arbiter in front of the SDRAM slave port.
// Latency: idle-to-grant takes 1 cycle; owner-to-owner handover takes 0 idle cycles.
// Backpressure: the owner keeps the slave until it drops cyc; a waiting master sees no ack.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   m0_* / m1_*                   Wishbone master ports (0 = video read, 1 = test-pattern write)
//   s_*                           Wishbone port towards the SDRAM slave
//   gnt                           one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle
module wshb_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  // master 0
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat_ms,
  input  logic [DW/8-1:0] m0_sel,
  input  logic [2:0]      m0_cti,
  input  logic [1:0]      m0_bte,
  output logic            m0_ack,
  output logic [DW-1:0]   m0_dat_sm,
  // master 1
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat_ms,
  input  logic [DW/8-1:0] m1_sel,
  input  logic [2:0]      m1_cti,
  input  logic [1:0]      m1_bte,
  output logic            m1_ack,
  output logic [DW-1:0]   m1_dat_sm,
  // slave
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_ms,
  output logic [DW/8-1:0] s_sel,
  output logic [2:0]      s_cti,
  output logic [1:0]      s_bte,
  input  logic            s_ack,
  input  logic [DW-1:0]   s_dat_sm,
  // current owner
  output logic [1:0]      gnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state;
  logic   last_owner;   // master that most recently finished a cycle

  // Ownership is per Wishbone cycle; round-robin only decides contention
  // at the moment the current owner lets go (or from IDLE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;   // makes m0 the first winner after reset
    end else begin
      unique case (state)
        IDLE: begin
          if (m0_cyc && m1_cyc) state <= last_owner ? OWN0 : OWN1;
          else if (m0_cyc)      state <= OWN0;
          else if (m1_cyc)      state <= OWN1;
        end
        OWN0: begin
          if (!m0_cyc) begin
            last_owner <= 1'b0;
            state      <= m1_cyc ? OWN1 : IDLE;   // hand over on the same edge
          end
        end
        OWN1: begin
          if (!m1_cyc) begin
            last_owner <= 1'b1;
            state      <= m0_cyc ? OWN0 : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Since state resets asynchronously, s_cyc/s_stb drop as soon as rst rises,
  // abandoning any in-flight transfer.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    gnt      = 2'b00;
    unique case (state)
      OWN0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        m0_ack   = s_ack;
        gnt      = 2'b01;
      end
      OWN1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_ack   = s_ack;
        gnt      = 2'b10;
      end
      default: ;   // IDLE: stray slave acks are dropped here
    endcase
  end

  // Read data is broadcast; each master qualifies it with its own ack.
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_arbiter.sv
module tb_wshb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic rst;

  logic            m0_cyc, m0_stb, m0_we;
  logic [AW-1:0]   m0_adr;
  logic [DW-1:0]   m0_dat_ms;
  logic [DW/8-1:0] m0_sel;
  logic [2:0]      m0_cti;
  logic [1:0]      m0_bte;
  logic            m0_ack;
  logic [DW-1:0]   m0_dat_sm;

  logic            m1_cyc, m1_stb, m1_we;
  logic [AW-1:0]   m1_adr;
  logic [DW-1:0]   m1_dat_ms;
  logic [DW/8-1:0] m1_sel;
  logic [2:0]      m1_cti;
  logic [1:0]      m1_bte;
  logic            m1_ack;
  logic [DW-1:0]   m1_dat_sm;

  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_ms;
  logic [DW/8-1:0] s_sel;
  logic [2:0]      s_cti;
  logic [1:0]      s_bte;
  logic            s_ack;
  logic [DW-1:0]   s_dat_sm;
  logic [1:0]      gnt;

  // Slave model: zero-wait-state acks, read data tagged with the low address bits.
  logic slv_en;
  logic force_ack;
  assign s_ack    = force_ack | (slv_en & s_cyc & s_stb);
  assign s_dat_sm = {16'hDA7A, s_adr[15:0]};

  int checks   = 0;
  int failures = 0;

  // scoreboard queues
  logic [1:0] gnt_q[$];
  int         acks_q[$];
  logic [31:0] dat_q[$];

  wshb_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_dat_sm(s_dat_sm),
    .gnt(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_ms = '0;
    m0_sel = '0; m0_cti = '0; m0_bte = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_ms = '0;
    m1_sel = '0; m1_cti = '0; m1_bte = '0;
    slv_en = 0; force_ack = 0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [1:0]  prev_g, exp_g;
  logic [31:0] a0, a1, exp_d;
  logic        ack0, ack1;
  int          grant_acks, n0, n1, ends, cyc_cnt;

  initial begin
    rst = 1'b1;
    idle_inputs();

    // ---------------- reset state ----------------
    #3;
    chk("rst_gnt",   gnt, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_s_stb", s_stb, 1'b0);
    chk("rst_s_adr", s_adr, 32'h0);
    chk("rst_acks",  {m0_ack, m1_ack}, 2'b00);

    // ---------------- single master 0 ----------------
    reset_dut();
    slv_en = 1; m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100; m0_sel = 4'hF;
    dat_q.push_back(32'hDA7A_0100);
    #1;
    chk("t1_gnt_before", gnt, 2'b00);
    chk("t1_ack_before", m0_ack, 1'b0);
    @(posedge clk); #1;
    chk("t1_gnt",   gnt, 2'b01);
    chk("t1_s_adr", s_adr, 32'h100);
    chk("t1_s_sel", s_sel, 4'hF);
    chk("t1_m0_ack", m0_ack, s_ack);
    chk("t1_m0_ack_hi", m0_ack, 1'b1);
    chk("t1_m1_ack", m1_ack, 1'b0);
    exp_d = dat_q.pop_front();
    chk("t1_m0_dat", m0_dat_sm, exp_d);
    chk("t1_m1_dat_bcast", m1_dat_sm, exp_d);
    m0_cyc = 0; m0_stb = 0;
    @(posedge clk); #1;
    chk("t1_release", gnt, 2'b00);

    // ---------------- contention, round-robin ----------------
    reset_dut();
    gnt_q = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    acks_q = '{4, 4, 4, 4};
    slv_en = 1;
    a0 = 32'h1000; a1 = 32'h2000;
    m0_cyc = 1; m0_stb = 1; m0_adr = a0;
    m1_cyc = 1; m1_stb = 1; m1_adr = a1;
    prev_g = 2'b00; grant_acks = 0; n0 = 0; n1 = 0; ends = 0; cyc_cnt = 0;
    while (ends < 4 && cyc_cnt < 200) begin
      @(negedge clk);
      cyc_cnt++;
      if (gnt != prev_g) begin
        if (prev_g != 2'b00) begin
          chk("rr_acksq_nonempty", acks_q.size() != 0, 1'b1);
          if (acks_q.size() != 0) chk("rr_acks_per_grant", grant_acks, acks_q.pop_front());
          ends++;
        end
        chk("rr_gntq_nonempty", gnt_q.size() != 0, 1'b1);
        if (gnt_q.size() != 0) begin
          exp_g = gnt_q.pop_front();
          chk("rr_gnt", gnt, exp_g);
        end
        grant_acks = 0;
        prev_g = gnt;
      end
      ack0 = m0_ack;
      ack1 = m1_ack;
      if (ack0) begin
        grant_acks++; n0++;
        chk("rr_m0_dat", m0_dat_sm, {16'hDA7A, a0[15:0]});
        chk("rr_m0_only", {m1_ack, gnt}, {1'b0, 2'b01});
      end
      if (ack1) begin
        grant_acks++; n1++;
        chk("rr_m1_dat", m1_dat_sm, {16'hDA7A, a1[15:0]});
        chk("rr_m1_only", {m0_ack, gnt}, {1'b0, 2'b10});
      end
      @(posedge clk); #1;
      // each master drops cyc for one cycle after its 4th ack, then asks again
      if (!m0_cyc) begin
        m0_cyc = 1; m0_stb = 1;
      end else if (ack0) begin
        a0 += 4; m0_adr = a0;
        if (n0 == 4) begin m0_cyc = 0; m0_stb = 0; n0 = 0; end
      end
      if (!m1_cyc) begin
        m1_cyc = 1; m1_stb = 1;
      end else if (ack1) begin
        a1 += 4; m1_adr = a1;
        if (n1 == 4) begin m1_cyc = 0; m1_stb = 0; n1 = 0; end
      end
    end
    chk("rr_done", ends, 4);
    chk("rr_queues_drained", gnt_q.size() + acks_q.size(), 0);

    // ---------------- m1 owns, m0 must wait ----------------
    reset_dut();
    slv_en = 1;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h200; m1_dat_ms = 32'h00FF_FF00;
    @(posedge clk); #1;
    chk("t4_gnt_m1", gnt, 2'b10);
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h100; m0_dat_ms = 32'hAAAA_5555;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t4_m0_no_ack", m0_ack, 1'b0);
      chk("t4_m1_ack", m1_ack, 1'b1);
      chk("t4_s_fields", {s_we, s_adr, s_dat_ms}, {1'b1, 32'h200, 32'h00FF_FF00});
    end
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    @(posedge clk); #1;   // m1 cycle-end seen on this edge
    @(posedge clk); #1;
    chk("t4_gnt_m0", gnt, 2'b01);
    chk("t4_s_fields_m0", {s_we, s_adr, s_dat_ms}, {1'b0, 32'h100, 32'hAAAA_5555});
    chk("t4_m0_ack", m0_ack, 1'b1);

    // ---------------- reset in the middle of an m1 cycle ----------------
    reset_dut();
    slv_en = 1;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h300;
    @(posedge clk); #1;
    chk("t5_gnt_m1", gnt, 2'b10);
    #1 rst = 1'b1;
    #1;
    chk("t5_async_s_cyc_stb", {s_cyc, s_stb}, 2'b00);
    chk("t5_async_gnt", gnt, 2'b00);
    chk("t5_async_acks", {m0_ack, m1_ack}, 2'b00);
    #1 rst = 1'b0;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h400;
    @(posedge clk); #1;
    chk("t5_m0_first", gnt, 2'b01);

    // ---------------- stray ack while idle ----------------
    reset_dut();
    force_ack = 1;
    #1;
    chk("t6_acks_idle", {m0_ack, m1_ack}, 2'b00);
    @(posedge clk); #1;
    chk("t6_stay_idle", gnt, 2'b00);
    chk("t6_acks_idle2", {m0_ack, m1_ack}, 2'b00);
    force_ack = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
